// File: rtl/t06_pwm_gen.sv
// t06_pwm_gen: shared-counter multi-channel PWM with double-buffered period/duty/mode
module t06_pwm_gen #(
  parameter int WIDTH    = 19,
  parameter int CHANNELS = 4,
  parameter int STEP     = 10
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       polarity,
  input  logic                      load,
  output logic [CHANNELS-1:0]       out,
  output logic                      period_end,
  output logic                      update_pending,
  output logic [WIDTH-1:0]          count
);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);
  logic [WIDTH-1:0]          period_p, period_a, cnt_nxt;
  logic [CHANNELS*WIDTH-1:0] duty_p, duty_a;
  logic                      mode_p, mode_a, dir, dir_nxt, wrap, top, e_wrap;
  logic [WIDTH:0]            cnt_up;
  logic [CHANNELS-1:0]       out_reg, raw;
  // dir: 0 = counting up, 1 = counting down (center-aligned only)
  always_comb begin
    cnt_up  = {1'b0, count} + STEP_X;
    top     = cnt_up >= {1'b0, period_a};
    e_wrap  = count >= period_a || cnt_up > {1'b0, period_a};
    wrap    = period_a == '0 || (mode_a ? dir && count <= STEP_N : e_wrap);
    cnt_nxt = wrap ? '0 : !mode_a ? cnt_up[WIDTH-1:0] : dir ? count - STEP_N : top ? period_a : cnt_up[WIDTH-1:0];
    dir_nxt = !wrap && mode_a && (dir || top);
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
    assign raw[i] = count < duty_a[i*WIDTH +: WIDTH];
  end
  assign out = out_reg ^ polarity;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count          <= '0;
      dir            <= 1'b0;
      period_end     <= 1'b0;
      out_reg        <= '0;
      update_pending <= 1'b0;
      period_p       <= '0;
      duty_p         <= '0;
      mode_p         <= 1'b0;
      period_a       <= '0;
      duty_a         <= '0;
      mode_a         <= 1'b0;
    end else begin
      count      <= enable ? cnt_nxt : '0;
      dir        <= enable && dir_nxt;
      period_end <= enable && wrap;
      out_reg    <= enable ? raw : '0;
      if (load) begin
        period_p <= period;
        duty_p   <= duty;
        mode_p   <= mode;
      end
      if (load && (!enable || wrap)) begin
        period_a       <= period;
        duty_a         <= duty;
        mode_a         <= mode;
        update_pending <= 1'b0;
      end else if (load) begin
        update_pending <= 1'b1;
      end else if (enable && wrap && update_pending) begin
        period_a       <= period_p;
        duty_a         <= duty_p;
        mode_a         <= mode_p;
        update_pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_t06_pwm_gen.sv
// tb_t06_pwm_gen: directed + random stimulus against a period-sequence reference model
module tb_t06_pwm_gen;
  localparam int W = 19, C = 4, S = 10;
  logic             clk = 1'b0, nrst = 1'b0, en = 1'b0, md = 1'b0, ld = 1'b0;
  logic [W-1:0]     per = '0, cnt;
  logic [C*W-1:0]   du = '0;
  logic [C-1:0]     pol = 4'b0101, out_s;
  logic             pe, up;
  int               checks = 0, errors = 0;
  // reference model: active/pending settings and position k within the period sequence
  int               m_p = 0, p_p = 0, k = 0;
  bit               m_md = 0, p_md = 0, m_pend = 0, m_pe = 0;
  int               m_du[C], p_du[C];
  logic [C-1:0]     m_out = '0;

  t06_pwm_gen #(.WIDTH(W), .CHANNELS(C), .STEP(S)) dut (
    .clk(clk), .nrst(nrst), .enable(en), .mode(md), .period(per), .duty(du),
    .polarity(pol), .load(ld), .out(out_s), .period_end(pe),
    .update_pending(up), .count(cnt)
  );

  always #5 clk = ~clk;

  function automatic int seq_len(int p, bit m);
    if (p == 0) return 1;
    return m ? 2 * ((p + S - 1) / S) : p / S + 1;
  endfunction

  function automatic int seq_val(int p, bit m, int idx);
    int n;
    if (p == 0) return 0;
    if (!m) return idx * S;
    n = (p + S - 1) / S;
    if (idx < n) return idx * S;
    if (idx == n) return p;
    return p - (idx - n) * S;
  endfunction

  task automatic model_reset();
    m_p = 0; p_p = 0; k = 0; m_md = 0; p_md = 0; m_pend = 0; m_pe = 0; m_out = '0;
    for (int i = 0; i < C; i++) begin m_du[i] = 0; p_du[i] = 0; end
  endtask

  task automatic model_edge();
    int cur;
    bit wr;
    cur = seq_val(m_p, m_md, k);
    wr = en && (k == seq_len(m_p, m_md) - 1);
    for (int i = 0; i < C; i++) m_out[i] = en && (cur < m_du[i]);
    m_pe = wr;
    k = (!en || wr) ? 0 : k + 1;
    if (ld) begin
      p_p = int'(per); p_md = md;
      for (int i = 0; i < C; i++) p_du[i] = int'(du[i*W +: W]);
    end
    if (ld && (!en || wr)) begin
      m_p = p_p; m_md = p_md; m_pend = 0;
      for (int i = 0; i < C; i++) m_du[i] = p_du[i];
    end else if (ld) begin
      m_pend = 1;
    end else if (wr && m_pend) begin
      m_p = p_p; m_md = p_md; m_pend = 0;
      for (int i = 0; i < C; i++) m_du[i] = p_du[i];
    end
  endtask

  task automatic check_all(string tag);
    logic [W-1:0] ec;
    logic [C-1:0] eo;
    ec = W'(seq_val(m_p, m_md, k));
    eo = m_out ^ pol;
    checks++;
    assert (cnt === ec) else begin errors++; $error("FAIL %s count: got %0d expected %0d", tag, cnt, ec); end
    checks++;
    assert (out_s === eo) else begin errors++; $error("FAIL %s out: got %b expected %b", tag, out_s, eo); end
    checks++;
    assert (pe === m_pe) else begin errors++; $error("FAIL %s period_end: got %b expected %b", tag, pe, m_pe); end
    checks++;
    assert (up === m_pend) else begin errors++; $error("FAIL %s update_pending: got %b expected %b", tag, up, m_pend); end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    ld = 1'b0;
  endtask

  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set_duty(int ch, int v);
    du[ch*W +: W] = W'(v);
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    #1 nrst = 1'b1;
    // edge-aligned, period 100, duty0 30, loaded while disabled (direct)
    per = W'(100); md = 1'b0; set_duty(0, 30); ld = 1'b1;
    step("load_idle");
    en = 1'b1;
    run("edge100", 16);
    per = W'(100); set_duty(0, 60); ld = 1'b1;
    run("edge_reload", 30);
    // center-aligned, period 50, duty1 20, buffered until wrap
    per = W'(50); md = 1'b1; set_duty(1, 20); ld = 1'b1;
    run("center50", 30);
    // duty extremes with inverted channel 3
    pol = 4'b1000; md = 1'b0; per = W'(100); set_duty(2, 0); set_duty(3, 200); ld = 1'b1;
    run("extremes", 25);
    // load on the exact wrap cycle
    while (k != seq_len(m_p, m_md) - 1) step("to_wrap");
    per = W'(40); ld = 1'b1;
    step("load_at_wrap");
    run("edge40", 12);
    // asynchronous reset mid-count
    run("pre_reset", 3);
    #2 nrst = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #1 nrst = 1'b1;
    run("post_reset", 3);
    per = W'(70); md = 1'b0; set_duty(0, 35); ld = 1'b1;
    run("post_reset_load", 12);
    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 11) == 0) begin
        ld = 1'b1;
        per = W'($urandom_range(0, 250));
        md = 1'($urandom_range(0, 1));
        for (int i = 0; i < C; i++) set_duty(i, $urandom_range(0, 270));
      end
      if ($urandom_range(0, 31) == 0) pol = C'($urandom_range(0, 15));
      step("random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
